// File: rtl/keypad_pkg.sv
// Shared types, constants and key-code mapping for the matrix keypad scanner.
package keypad_pkg;

  localparam int MAX_CODE_W = 8;
  localparam logic [MAX_CODE_W-1:0] NO_KEY = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } kp_state_e;

  // col 0 is the leftmost key (column MSB); a 4x3 phone pad puts *,0,# on the bottom row
  function automatic int code_of(input int row, input int col, input int rows,
                                 input int cols, input bit tel_map);
    int code;
    if (tel_map && rows == 4 && cols == 3 && row == 3) begin
      case (col)
        0:       code = 10;
        1:       code = 0;
        default: code = 11;
      endcase
    end else begin
      code = row * cols + col + 1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row-select sequencer: holds each row for SCAN_DIV cycles and strobes the column sample.
module keypad_row_scan #(
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 50000,
  localparam int SEL_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int DIV_W   = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [SEL_W-1:0] sel,
  output logic             sample,
  output logic             frame_end
);

  logic [DIV_W-1:0] div_cnt_r;
  logic [SEL_W-1:0] sel_r;

  assign sample    = (div_cnt_r == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample && (sel_r == SEL_W'(ROWS - 1));
  assign sel       = sel_r;

  // dwell counter and row index, advancing together on the sample cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
      sel_r     <= '0;
    end else if (sample) begin
      div_cnt_r <= '0;
      sel_r     <= (sel_r == SEL_W'(ROWS - 1)) ? '0 : sel_r + SEL_W'(1);
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Self-scanning keypad front end: per-frame single-key detection, debounce FSM, press/release pulses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int TEL_MAP  = 1,
  localparam int SEL_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CODE_W  = $clog2(ROWS * COLS + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   column,
  output logic [SEL_W-1:0]  sel,
  output logic [CODE_W-1:0] scan_code,
  output logic              press,
  output logic              key_valid,
  output logic              key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CODE_W-1:0] NO_CODE = NO_KEY[CODE_W-1:0];

  logic              sample_s, frame_end_s;
  logic              row_hit_s;
  logic [CODE_W-1:0] row_code_s, code_s, result_s;
  logic [1:0]        hits_s;
  int                zero_cnt_s;

  logic [CODE_W-1:0] acc_code_r, cand_r, scan_code_r;
  logic [1:0]        acc_hits_r;
  logic [CNT_W-1:0]  cnt_r;
  kp_state_e         state_r;
  logic              press_r, key_valid_r, key_release_r;

  kp_state_e         state_n;
  logic [CODE_W-1:0] cand_n, code_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W:0]    cnt_inc_s;
  logic              press_n, valid_n, rel_n, deb_done_s;

  keypad_row_scan #(.ROWS(ROWS), .SCAN_DIV(SCAN_DIV)) u_row_scan (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .sample    (sample_s),
    .frame_end (frame_end_s)
  );

  // decode the current row: exactly one low column is a key, anything else is none
  always_comb begin
    zero_cnt_s = 0;
    row_code_s = NO_CODE;
    for (int b = 0; b < COLS; b++) begin
      if (!column[b]) begin
        zero_cnt_s = zero_cnt_s + 1;
        row_code_s = CODE_W'(code_of(int'(sel), COLS - 1 - b, ROWS, COLS, TEL_MAP != 0));
      end else begin
        zero_cnt_s = zero_cnt_s;
      end
    end
    row_hit_s = (zero_cnt_s == 1);
  end

  // hit count saturates at 2: a second keyed row makes the frame a ghost
  assign hits_s   = (row_hit_s && acc_hits_r != 2'd2) ? acc_hits_r + 2'd1 : acc_hits_r;
  assign code_s   = row_hit_s ? row_code_s : acc_code_r;
  assign result_s = (hits_s == 2'd1) ? code_s : NO_CODE;

  // frame accumulator, cleared once the frame result has been consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hits_r <= 2'd0;
      acc_code_r <= NO_CODE;
    end else if (sample_s && frame_end_s) begin
      acc_hits_r <= 2'd0;
      acc_code_r <= NO_CODE;
    end else if (sample_s) begin
      acc_hits_r <= hits_s;
      acc_code_r <= code_s;
    end else begin
      acc_hits_r <= acc_hits_r;
      acc_code_r <= acc_code_r;
    end
  end

  assign cnt_inc_s  = {1'b0, cnt_r} + (CNT_W + 1)'(1);
  assign deb_done_s = (cnt_inc_s >= (CNT_W + 1)'(DEBOUNCE));

  // debounce FSM, stepped only on frame-end cycles
  always_comb begin
    state_n = state_r;
    cand_n  = cand_r;
    cnt_n   = cnt_r;
    code_n  = scan_code_r;
    press_n = press_r;
    valid_n = 1'b0;
    rel_n   = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (result_s != NO_CODE) begin
            cand_n = result_s;
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE <= 1) begin
              state_n = HELD;
              code_n  = result_s;
              press_n = 1'b1;
              valid_n = 1'b1;
            end else begin
              state_n = DEB_PRESS;
            end
          end else begin
            state_n = IDLE;
          end
        end
        DEB_PRESS: begin
          if (result_s == NO_CODE) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (result_s != cand_r) begin
            cand_n = result_s;
            cnt_n  = CNT_W'(1);
          end else if (deb_done_s) begin
            state_n = HELD;
            cnt_n   = '0;
            code_n  = cand_r;
            press_n = 1'b1;
            valid_n = 1'b1;
          end else begin
            cnt_n = cnt_inc_s[CNT_W-1:0];
          end
        end
        HELD: begin
          if (result_s == scan_code_r) begin
            state_n = HELD;
          end else if (DEBOUNCE <= 1) begin
            state_n = IDLE;
            code_n  = NO_CODE;
            press_n = 1'b0;
            rel_n   = 1'b1;
          end else begin
            state_n = DEB_REL;
            cnt_n   = CNT_W'(1);
          end
        end
        DEB_REL: begin
          if (result_s == scan_code_r) begin
            state_n = HELD;
            cnt_n   = '0;
          end else if (deb_done_s) begin
            state_n = IDLE;
            cnt_n   = '0;
            code_n  = NO_CODE;
            press_n = 1'b0;
            rel_n   = 1'b1;
          end else begin
            cnt_n = cnt_inc_s[CNT_W-1:0];
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          code_n  = NO_CODE;
          press_n = 1'b0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // FSM and output registers; reset drops a held key silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cand_r        <= NO_CODE;
      cnt_r         <= '0;
      scan_code_r   <= NO_CODE;
      press_r       <= 1'b0;
      key_valid_r   <= 1'b0;
      key_release_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      cand_r        <= cand_n;
      cnt_r         <= cnt_n;
      scan_code_r   <= code_n;
      press_r       <= press_n;
      key_valid_r   <= valid_n;
      key_release_r <= rel_n;
    end
  end

  assign scan_code   = scan_code_r;
  assign press       = press_r;
  assign key_valid   = key_valid_r;
  assign key_release = key_release_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x3 phone pad, SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] column;
  logic [1:0] sel;
  logic [3:0] scan_code;
  logic       press, key_valid, key_release;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_rel = 0;

  logic       k1_en = 1'b0, k2_en = 1'b0;
  logic [1:0] k1_row = 2'd0, k2_row = 2'd0;
  logic [2:0] k1_pat = 3'b111, k2_pat = 3'b111;

  keypad_scanner #(
    .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(3), .TEL_MAP(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .column      (column),
    .sel         (sel),
    .scan_code   (scan_code),
    .press       (press),
    .key_valid   (key_valid),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // physical keypad: a closed switch pulls its column low only while its row is selected
  assign column = ((k1_en && sel == k1_row) ? k1_pat : 3'b111) &
                  ((k2_en && sel == k2_row) ? k2_pat : 3'b111);

  // cycle index since the last reset edge; frame f ends at cycle 16*f-1
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    n_rel = 0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      if (key_valid)   n_valid++;
      if (key_release) n_rel++;
    end
  endtask

  task automatic set_key1(input logic en, input logic [1:0] row, input logic [2:0] pat);
    k1_en = en; k1_row = row; k1_pat = pat;
  endtask

  task automatic test_reset();
    k1_en = 1'b0; k2_en = 1'b0;
    do_reset();
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (scan_code !== 4'hF) begin failures++; $display("FAIL reset_code: got %h want f", scan_code); end
    checks++; if (press !== 1'b0) begin failures++; $display("FAIL reset_press: got %b want 0", press); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    checks++; if (key_release !== 1'b0) begin failures++; $display("FAIL reset_release: got %b want 0", key_release); end
    goto(4);
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL sel_advance: got %0d want 1", sel); end
    goto(16);
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL sel_wrap: got %0d want 0", sel); end
  endtask

  task automatic test_press();
    do_reset();
    set_key1(1'b1, 2'd1, 3'b101);
    goto(47);
    checks++; if (key_valid !== 1'b0 || n_valid != 0) begin failures++; $display("FAIL press_early: valid=%b count=%0d want 0", key_valid, n_valid); end
    goto(48);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press_valid: got %b want 1", key_valid); end
    checks++; if (scan_code !== 4'd5) begin failures++; $display("FAIL press_code: got %0d want 5", scan_code); end
    checks++; if (press !== 1'b1) begin failures++; $display("FAIL press_level: got %b want 1", press); end
    n_valid = 0;
    goto(96);
    checks++; if (n_valid != 0) begin failures++; $display("FAIL press_repeat: got %0d pulses want 0", n_valid); end
    checks++; if (press !== 1'b1 || scan_code !== 4'd5) begin failures++; $display("FAIL press_hold: press=%b code=%0d want 1/5", press, scan_code); end
  endtask

  task automatic test_release();
    set_key1(1'b0, 2'd0, 3'b111);
    n_rel = 0;
    goto(143);
    checks++; if (n_rel != 0 || press !== 1'b1) begin failures++; $display("FAIL release_early: pulses=%0d press=%b want 0/1", n_rel, press); end
    goto(144);
    checks++; if (key_release !== 1'b1) begin failures++; $display("FAIL release_pulse: got %b want 1", key_release); end
    checks++; if (scan_code !== 4'hF || press !== 1'b0) begin failures++; $display("FAIL release_state: code=%h press=%b want f/0", scan_code, press); end
    goto(145);
    checks++; if (key_release !== 1'b0) begin failures++; $display("FAIL release_width: got %b want 0", key_release); end
  endtask

  task automatic test_tel_codes();
    logic [1:0] rows [3] = '{2'd3, 2'd3, 2'd0};
    logic [2:0] pats [3] = '{3'b101, 3'b011, 3'b110};
    logic [3:0] want [3] = '{4'd0, 4'd10, 4'd3};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      set_key1(1'b1, rows[i], pats[i]);
      goto(48);
      checks++; if (key_valid !== 1'b1 || scan_code !== want[i]) begin failures++; $display("FAIL tel_code_%0d: valid=%b code=%0d want 1/%0d", i, key_valid, scan_code, want[i]); end
    end
    set_key1(1'b0, 2'd0, 3'b111);
  endtask

  task automatic test_bounce();
    do_reset();
    set_key1(1'b1, 2'd2, 3'b101);
    goto(32);
    set_key1(1'b0, 2'd2, 3'b101);
    goto(48);
    set_key1(1'b1, 2'd2, 3'b101);
    goto(80);
    set_key1(1'b0, 2'd2, 3'b101);
    goto(96);
    set_key1(1'b1, 2'd2, 3'b101);
    goto(143);
    checks++; if (n_valid != 0 || press !== 1'b0) begin failures++; $display("FAIL bounce_reject: pulses=%0d press=%b want 0/0", n_valid, press); end
    goto(144);
    checks++; if (key_valid !== 1'b1 || scan_code !== 4'd8) begin failures++; $display("FAIL bounce_accept: valid=%b code=%0d want 1/8", key_valid, scan_code); end
    set_key1(1'b0, 2'd0, 3'b111);
  endtask

  task automatic test_ghost();
    do_reset();
    set_key1(1'b1, 2'd0, 3'b011);
    k2_en = 1'b1; k2_row = 2'd2; k2_pat = 3'b110;
    goto(96);
    checks++; if (n_valid != 0 || press !== 1'b0) begin failures++; $display("FAIL ghost_rows: pulses=%0d press=%b want 0/0", n_valid, press); end
    k2_en = 1'b0;
    do_reset();
    set_key1(1'b1, 2'd1, 3'b001);
    goto(96);
    checks++; if (n_valid != 0 || n_rel != 0 || press !== 1'b0) begin failures++; $display("FAIL ghost_cols: valid=%0d rel=%0d press=%b want 0/0/0", n_valid, n_rel, press); end
    set_key1(1'b0, 2'd0, 3'b111);
  endtask

  task automatic test_reset_held();
    do_reset();
    set_key1(1'b1, 2'd2, 3'b110);
    goto(48);
    checks++; if (press !== 1'b1 || scan_code !== 4'd9) begin failures++; $display("FAIL held9: press=%b code=%0d want 1/9", press, scan_code); end
    goto(60);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (press !== 1'b0 || scan_code !== 4'hF) begin failures++; $display("FAIL rst_held_out: press=%b code=%h want 0/f", press, scan_code); end
    checks++; if (sel !== 2'd0 || key_release !== 1'b0) begin failures++; $display("FAIL rst_held_sel: sel=%0d rel=%b want 0/0", sel, key_release); end
    rst = 1'b0;
    n_valid = 0;
    n_rel = 0;
    goto(47);
    checks++; if (n_valid != 0 || n_rel != 0) begin failures++; $display("FAIL rst_held_quiet: valid=%0d rel=%0d want 0/0", n_valid, n_rel); end
    goto(48);
    checks++; if (key_valid !== 1'b1 || scan_code !== 4'd9) begin failures++; $display("FAIL rst_held_again: valid=%b code=%0d want 1/9", key_valid, scan_code); end
    set_key1(1'b0, 2'd0, 3'b111);
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_tel_codes();
    test_bounce();
    test_ghost();
    test_reset_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
